div_unit: RTL

Iterative 32-bit divider that serves the `div`/`divu` handshake issued by the instruction controller. It accepts a one-cycle start request, stays busy while it computes, and pulses a completion flag with quotient and remainder registered for the HI/LO write path. The stall logic holds the PC while busy or start is high, and depends on the busy-to-over ordering defined under Timing.

---
 rtl/div_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider for div/divu: one quotient bit per cycle,
// sign fix applied on the last step, registered busy/over handshake per mode.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_div,
    input  logic        start_divu,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy_div,
    output logic        busy_divu,
    output logic        over_div,
    output logic        over_divu,
    output logic [31:0] q,
    output logic [31:0] r
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic        mode, mode_next;           // 1 = signed
    logic [4:0]  count;
    logic [31:0] rem, quo, dvsr, dvnd_raw;
    logic        qneg, rneg, dvsr_zero;

    logic [32:0] rem_sh, diff;
    logic [31:0] rem_step, quo_step;
    logic        take_start, last_step;

    assign take_start = (state == IDLE) && (start_div || start_divu);
    assign last_step  = (state == RUN) && (count == 5'd31);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        mode_next  = mode;
        case (state)
            IDLE: if (take_start) begin
                state_next = RUN;
                mode_next  = start_div;
            end
            RUN:     if (count == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: the 33-bit trial value's top bit is the borrow.
    always_comb begin
        rem_sh = {rem, quo[31]};
        diff   = rem_sh - {1'b0, dvsr};
        if (!diff[32]) begin
            rem_step = diff[31:0];
            quo_step = {quo[30:0], 1'b1};
        end else begin
            rem_step = rem_sh[31:0];
            quo_step = {quo[30:0], 1'b0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // Handshake flags are computed from next-state so they are true flops, not decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode      <= 1'b0;
            busy_div  <= 1'b0;
            busy_divu <= 1'b0;
            over_div  <= 1'b0;
            over_divu <= 1'b0;
        end else begin
            state     <= state_next;
            mode      <= mode_next;
            busy_div  <= (state_next == RUN)  &&  mode_next;
            busy_divu <= (state_next == RUN)  && !mode_next;
            over_div  <= (state_next == DONE) &&  mode_next;
            over_divu <= (state_next == DONE) && !mode_next;
        end
    end

    // NOTE: datapath registers are reset too, so q/r read 0 after reset rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 5'd0;
            rem       <= 32'd0;
            quo       <= 32'd0;
            dvsr      <= 32'd0;
            dvnd_raw  <= 32'd0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            dvsr_zero <= 1'b0;
            q         <= 32'd0;
            r         <= 32'd0;
        end else if (take_start) begin
            count     <= 5'd0;
            rem       <= 32'd0;
            quo       <= (start_div && dividend[31]) ? -dividend : dividend;
            dvsr      <= (start_div && divisor[31])  ? -divisor  : divisor;
            dvnd_raw  <= dividend;
            qneg      <= start_div && (dividend[31] ^ divisor[31]);
            rneg      <= start_div && dividend[31];
            dvsr_zero <= (divisor == 32'd0);
        end else if (state == RUN) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 5'd1;
            if (last_step) begin
                if (dvsr_zero) begin
                    q <= 32'hFFFF_FFFF;
                    r <= dvnd_raw;
                end else begin
                    q <= qneg ? -quo_step : quo_step;
                    r <= rneg ? -rem_step : rem_step;
                end
            end
        end
    end

endmodule
